// File: rtl/mem_stage_sl_pkg.sv
// mem_stage_sl_pkg: shared bus-width helpers, load-op encodings and the
// MEM-stage state encoding used by the memory-access stage and its bench.
package mem_stage_sl_pkg;

  // Load operation encodings carried in ld_op; 5..7 behave as LW.
  localparam logic [2:0] LD_OP_LW  = 3'd0;
  localparam logic [2:0] LD_OP_LB  = 3'd1;
  localparam logic [2:0] LD_OP_LBU = 3'd2;
  localparam logic [2:0] LD_OP_LH  = 3'd3;
  localparam logic [2:0] LD_OP_LHU = 3'd4;

  // Occupancy of the stage: empty, waiting on a data response, or holding a result.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ms_state_e;

  // {ld_op[2:0], mem_req, res_from_mem, gr_we, dest, alu_result, pc}
  function automatic int es_to_ms_bus_wd(input int dw, input int dest_w, input int pc_w);
    return 3 + 1 + 1 + 1 + dest_w + dw + pc_w;
  endfunction

  // {gr_we, dest, final_result, pc}
  function automatic int ms_to_ws_bus_wd(input int dw, input int dest_w, input int pc_w);
    return 1 + dest_w + dw + pc_w;
  endfunction

endpackage

// File: rtl/mem_stage_sl_load_ext.sv
// mem_stage_sl_load_ext: selects the addressed byte/half of a load response
// and sign- or zero-extends it to the full data width.
module mem_stage_sl_load_ext
  import mem_stage_sl_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    ld_op,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] ext_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the byte lane and halfword lane addressed by the low address bits.
  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    if (addr[1]) begin
      half_sel = rdata[31:16];
    end else begin
      half_sel = rdata[15:0];
    end
  end

  // Extend the selected lane according to the load type; reserved ops act as LW.
  always_comb begin
    ext_data = rdata;
    case (ld_op)
      LD_OP_LB:  ext_data = {{(DW-8){byte_sel[7]}}, byte_sel};
      LD_OP_LBU: ext_data = {{(DW-8){1'b0}}, byte_sel};
      LD_OP_LH:  ext_data = {{(DW-16){half_sel[15]}}, half_sel};
      LD_OP_LHU: ext_data = {{(DW-16){1'b0}}, half_sel};
      LD_OP_LW:  ext_data = rdata;
      default:   ext_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_sl.sv
// mem_stage_sl: MIPS MEM stage with a variable-latency data SRAM response,
// sub-word load extension, absorption of responses owned by flushed loads and
// a forwarding record that tells decode when a load result is still pending.
module mem_stage_sl
  import mem_stage_sl_pkg::*;
#(
  parameter int DW          = 32,
  parameter int DEST_W      = 5,
  parameter int PC_W        = 32,
  parameter int MAX_DISCARD = 3
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        ws_allowin,
  output logic                                        ms_allowin,
  input  logic                                        es_to_ms_valid,
  input  logic [es_to_ms_bus_wd(DW, DEST_W, PC_W)-1:0] es_to_ms_bus,
  output logic                                        ms_to_ws_valid,
  output logic [ms_to_ws_bus_wd(DW, DEST_W, PC_W)-1:0] ms_to_ws_bus,
  input  logic                                        ms_flush,
  input  logic                                        data_sram_data_ok,
  input  logic [DW-1:0]                               data_sram_rdata,
  output logic                                        ms_to_ds_valid,
  output logic [DEST_W-1:0]                           ms_to_ds_dest,
  output logic [DW-1:0]                               ms_to_ds_result,
  output logic                                        ms_to_ds_block
);

  localparam int ES_W           = es_to_ms_bus_wd(DW, DEST_W, PC_W);
  localparam int DISC_W         = $clog2(MAX_DISCARD + 1);
  localparam int IN_MEM_REQ_BIT = PC_W + DW + DEST_W + 2;

  localparam logic [DISC_W-1:0] DISC_ZERO = {DISC_W{1'b0}};
  localparam logic [DISC_W-1:0] DISC_ONE  = DISC_W'(1);
  localparam logic [DISC_W-1:0] DISC_MAX  = DISC_W'(MAX_DISCARD);

  ms_state_e         state;
  ms_state_e         state_next;
  logic [ES_W-1:0]   ms_bus;
  logic [DW-1:0]     hold_rdata;
  logic [DISC_W-1:0] discard;

  // Fields of the instruction currently held by the stage.
  logic [2:0]        ld_op;
  logic              mem_req;
  logic              res_from_mem;
  logic              gr_we;
  logic [DEST_W-1:0] dest;
  logic [DW-1:0]     alu_result;
  logic [PC_W-1:0]   pc;

  assign {ld_op, mem_req, res_from_mem, gr_we, dest, alu_result, pc} = ms_bus;

  logic          in_mem_req;
  logic          ms_valid;
  logic          resp_hit;
  logic          ms_ready_go;
  logic          disc_full;
  logic          accept;
  logic          handoff;
  logic          disc_inc;
  logic          disc_dec;
  logic [DW-1:0] load_data;
  logic [DW-1:0] ext_data;
  logic [DW-1:0] final_result;

  assign in_mem_req = es_to_ms_bus[IN_MEM_REQ_BIT];

  // State register: async reset returns the stage to EMPTY, dropping any outstanding response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next state: flush empties, accept loads the new instruction, handoff empties, response readies.
  always_comb begin
    state_next = state;
    if (ms_flush) begin
      state_next = ST_EMPTY;
    end else if (accept) begin
      state_next = in_mem_req ? ST_WAIT : ST_READY;
    end else if (handoff) begin
      state_next = ST_EMPTY;
    end else if (resp_hit) begin
      state_next = ST_READY;
    end else begin
      state_next = state;
    end
  end

  // Handshake, forwarding flags and discard-counter controls derived from the state.
  always_comb begin
    ms_valid       = (state != ST_EMPTY);
    // A response only belongs to the held load once all flushed responses are drained.
    resp_hit       = (state == ST_WAIT) && data_sram_data_ok && (discard == DISC_ZERO);
    ms_ready_go    = (state == ST_READY) || resp_hit;
    disc_full      = (discard == DISC_MAX);
    // No room left to remember another orphaned response, so hold back new memory ops.
    ms_allowin     = (!ms_valid || (ms_ready_go && ws_allowin)) && !ms_flush
                     && !(in_mem_req && disc_full);
    accept         = es_to_ms_valid && ms_allowin;
    handoff        = ms_ready_go && ws_allowin;
    ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    ms_to_ds_valid = ms_valid && gr_we && (dest != {DEST_W{1'b0}});
    ms_to_ds_block = ms_valid && res_from_mem && !ms_ready_go;
    // A flushed load whose response has not arrived leaves one response to swallow later.
    disc_inc       = ms_flush && (state == ST_WAIT) && !resp_hit;
    disc_dec       = data_sram_data_ok && (discard != DISC_ZERO);
  end

  // Instruction bus and load-data holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_bus     <= {ES_W{1'b0}};
      hold_rdata <= {DW{1'b0}};
    end else begin
      if (accept) begin
        ms_bus <= es_to_ms_bus;
      end
      if (resp_hit) begin
        hold_rdata <= data_sram_rdata;
      end
    end
  end

  // Count of responses still due for loads that were flushed while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard <= DISC_ZERO;
    end else begin
      case ({disc_inc, disc_dec})
        2'b10: begin
          if (!disc_full) begin
            discard <= discard + DISC_ONE;
          end
        end
        2'b01:   discard <= discard - DISC_ONE;
        default: discard <= discard;
      endcase
    end
  end

  // Raw response in its arrival cycle, captured copy afterwards; then pick load or ALU result.
  always_comb begin
    if (state == ST_READY) begin
      load_data = hold_rdata;
    end else begin
      load_data = data_sram_rdata;
    end
    if (res_from_mem) begin
      final_result = ext_data;
    end else begin
      final_result = alu_result;
    end
  end

  mem_stage_sl_load_ext #(
    .DW (DW)
  ) u_load_ext (
    .ld_op    (ld_op),
    .addr     (alu_result[1:0]),
    .rdata    (load_data),
    .ext_data (ext_data)
  );

  assign ms_to_ws_bus    = {gr_we, dest, final_result, pc};
  assign ms_to_ds_dest   = dest;
  assign ms_to_ds_result = final_result;

endmodule

// File: tb/tb_mem_stage_sl.sv
// tb_mem_stage_sl: directed scenarios followed by randomized traffic, all
// checked against a transaction-level reference model of the MEM stage.
module tb_mem_stage_sl;
  import mem_stage_sl_pkg::*;

  localparam int DW   = 32;
  localparam int DEST_W = 5;
  localparam int PC_W = 32;
  localparam int MAXD = 3;
  localparam int ES_W = es_to_ms_bus_wd(DW, DEST_W, PC_W);
  localparam int MS_W = ms_to_ws_bus_wd(DW, DEST_W, PC_W);

  typedef struct packed {
    logic [2:0]  ld_op;
    logic        mem_req;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } instr_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            ws_allowin;
  logic            ms_allowin;
  logic            es_to_ms_valid;
  logic [ES_W-1:0] es_to_ms_bus;
  logic            ms_to_ws_valid;
  logic [MS_W-1:0] ms_to_ws_bus;
  logic            ms_flush;
  logic            data_ok;
  logic [31:0]     rdata;
  logic            ds_valid;
  logic [4:0]      ds_dest;
  logic [31:0]     ds_result;
  logic            ds_block;
  instr_t          cur;

  assign es_to_ms_bus = cur;

  always #5 clk = ~clk;

  mem_stage_sl #(
    .DW (DW), .DEST_W (DEST_W), .PC_W (PC_W), .MAX_DISCARD (MAXD)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_flush          (ms_flush),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .ms_to_ds_valid    (ds_valid),
    .ms_to_ds_dest     (ds_dest),
    .ms_to_ds_result   (ds_result),
    .ms_to_ds_block    (ds_block)
  );

  // Reference model: the held instruction, whether its data has been kept, orphan count.
  bit          m_valid;
  instr_t      m_ins;
  bit          m_have;
  logic [31:0] m_data;
  int          m_disc;
  logic [31:0] resp_q[$];
  bit          e_arrive, e_ready, e_allow;
  int          checks = 0;
  int          passes = 0;

  function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [1:0] a,
                                          input logic [31:0] r);
    logic [31:0] v;
    case (op)
      3'd1: begin v = (r >> (8 * a)) & 32'hFF; if (v >= 32'd128) v = v - 32'd256; end
      3'd2: v = (r >> (8 * a)) & 32'hFF;
      3'd3: begin v = (r >> (16 * a[1])) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd4: v = (r >> (16 * a[1])) & 32'hFFFF;
      default: v = r;
    endcase
    return v;
  endfunction

  function automatic instr_t mk(input logic [2:0] op, input logic mem, input logic rfm,
                                input logic we, input logic [4:0] d, input logic [31:0] alu,
                                input logic [31:0] pc);
    instr_t i;
    i.ld_op = op; i.mem_req = mem; i.res_from_mem = rfm; i.gr_we = we;
    i.dest = d; i.alu = alu; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int k;
    k = $urandom_range(0, 3);
    i.alu = $urandom; i.pc = $urandom;
    i.dest = 5'($urandom_range(0, 31));
    i.ld_op = 3'($urandom_range(0, 7));
    case (k)
      0: begin i.mem_req = 1'b0; i.res_from_mem = 1'b0; i.gr_we = 1'($urandom_range(0, 1)); end
      3: begin i.mem_req = 1'b1; i.res_from_mem = 1'b0; i.gr_we = 1'b0; end
      default: begin i.mem_req = 1'b1; i.res_from_mem = 1'b1; i.gr_we = 1'b1; end
    endcase
    return i;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_have = 1'b0; m_disc = 0; m_ins = '0; m_data = '0;
    resp_q.delete();
  endtask

  // Compare every output against the model for the inputs applied this cycle.
  task automatic check_cycle();
    logic [31:0] ld, res;
    bit e_wsv, e_dsv, e_blk;
    #3;
    e_arrive = data_ok && (m_disc == 0) && m_valid && m_ins.mem_req && !m_have;
    e_ready  = m_valid && (!m_ins.mem_req || m_have || e_arrive);
    ld  = m_have ? m_data : rdata;
    res = m_ins.res_from_mem ? ref_ext(m_ins.ld_op, m_ins.alu[1:0], ld) : m_ins.alu;
    e_allow = (!m_valid || (e_ready && ws_allowin)) && !ms_flush
              && !(cur.mem_req && (m_disc == MAXD));
    e_wsv = e_ready && !ms_flush;
    e_dsv = m_valid && m_ins.gr_we && (m_ins.dest != 5'd0);
    e_blk = m_valid && m_ins.res_from_mem && !e_ready;
    chk("allowin", 128'(ms_allowin), 128'(e_allow));
    chk("ws_valid", 128'(ms_to_ws_valid), 128'(e_wsv));
    chk("ds_valid", 128'(ds_valid), 128'(e_dsv));
    chk("ds_block", 128'(ds_block), 128'(e_blk));
    if (e_wsv) chk("ws_bus", 128'(ms_to_ws_bus), 128'({m_ins.gr_we, m_ins.dest, res, m_ins.pc}));
    if (e_dsv && !e_blk) begin
      chk("ds_dest", 128'(ds_dest), 128'(m_ins.dest));
      chk("ds_result", 128'(ds_result), 128'(res));
    end
  endtask

  // Advance the model across the clock edge and track responses still owed by memory.
  task automatic advance();
    bit acc;
    int inc, dec;
    acc = es_to_ms_valid && e_allow;
    dec = (data_ok && m_disc > 0) ? 1 : 0;
    inc = (ms_flush && m_valid && m_ins.mem_req && !m_have && !e_arrive) ? 1 : 0;
    m_disc = m_disc + inc - dec;
    if (ms_flush) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_ins = cur; m_have = 1'b0; end
    else if (e_ready && ws_allowin) m_valid = 1'b0;
    else if (e_arrive) begin m_have = 1'b1; m_data = rdata; end
    if (data_ok && resp_q.size() > 0) void'(resp_q.pop_front());
    if (acc && cur.mem_req) resp_q.push_back($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    check_cycle();
    advance();
  endtask

  initial begin
    reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; ms_flush = 1'b0;
    data_ok = 1'b0; rdata = 32'h0; cur = '0;
    model_reset();
    #2;
    chk("rst_allowin", 128'(ms_allowin), 128'(1'b1));
    chk("rst_ws_valid", 128'(ms_to_ws_valid), 128'(1'b0));
    chk("rst_ds_valid", 128'(ds_valid), 128'(1'b0));
    chk("rst_block", 128'(ds_block), 128'(1'b0));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // ADD: result one cycle after accept.
    cur = mk(LD_OP_LW, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h100);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    check_cycle();
    chk("add_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    chk("add_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_1234));
    chk("add_blk", 128'(ds_block), 128'(1'b0));
    advance();

    // LB from byte 3 with three wait cycles.
    cur = mk(LD_OP_LB, 1'b1, 1'b1, 1'b1, 5'd3, 32'h0000_1003, 32'h104);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_cycle();
      chk("lb_wait_blk", 128'(ds_block), 128'(1'b1));
      chk("lb_wait_wsv", 128'(ms_to_ws_valid), 128'(1'b0));
      advance();
    end
    data_ok = 1'b1; rdata = 32'h80FF_0000;
    check_cycle();
    chk("lb_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    chk("lb_res", 128'(ms_to_ws_bus[63:32]), 128'(32'hFFFF_FF80));
    chk("lb_blk", 128'(ds_block), 128'(1'b0));
    advance(); data_ok = 1'b0;

    // LHU held while write-back stalls.
    cur = mk(LD_OP_LHU, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0000_2002, 32'h108);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0; data_ok = 1'b1; rdata = 32'hBEEF_0000;
    check_cycle();
    chk("lhu_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
    chk("lhu_allow", 128'(ms_allowin), 128'(1'b0));
    advance(); data_ok = 1'b0; rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      check_cycle();
      chk("lhu_hold_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0000_BEEF));
      chk("lhu_hold_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
      chk("lhu_hold_allow", 128'(ms_allowin), 128'(1'b0));
      advance();
    end
    ws_allowin = 1'b1;
    check_cycle();
    chk("lhu_release", 128'(ms_allowin), 128'(1'b1));
    advance();

    // Flush in WAIT, new LW: first response dropped, second belongs to new PC.
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h200);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    ms_flush = 1'b1;
    check_cycle();
    chk("fl_wsv", 128'(ms_to_ws_valid), 128'(1'b0));
    advance(); ms_flush = 1'b0;
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd10, 32'h0000_3004, 32'h204);
    es_to_ms_valid = 1'b1;
    check_cycle();
    chk("fl_accept", 128'(ms_allowin), 128'(1'b1));
    advance(); es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'hDEAD_DEAD;
    check_cycle();
    chk("fl_drop_wsv", 128'(ms_to_ws_valid), 128'(1'b0));
    chk("fl_drop_blk", 128'(ds_block), 128'(1'b1));
    advance();
    rdata = 32'h1111_2222;
    check_cycle();
    chk("fl_new_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    chk("fl_new_pc", 128'(ms_to_ws_bus[31:0]), 128'(32'h204));
    chk("fl_new_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h1111_2222));
    advance(); data_ok = 1'b0;

    // Flush coinciding with the response: nothing left to discard.
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd11, 32'h0000_3008, 32'h300);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    ms_flush = 1'b1; data_ok = 1'b1; rdata = 32'hAAAA_5555;
    check_cycle();
    chk("flok_wsv", 128'(ms_to_ws_valid), 128'(1'b0));
    advance(); ms_flush = 1'b0; data_ok = 1'b0;
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd12, 32'h0000_300C, 32'h304);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'h0BAD_F00D;
    check_cycle();
    chk("flok_next_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    chk("flok_next_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h0BAD_F00D));
    advance(); data_ok = 1'b0;

    // Saturate the orphan count: memory ops blocked, ALU ops still accepted.
    for (int i = 0; i < 3; i++) begin
      cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd13, 32'h0000_4000, 32'h500 + 32'(4 * i));
      es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
      ms_flush = 1'b1; cyc(); ms_flush = 1'b0;
    end
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd14, 32'h0000_4004, 32'h600);
    es_to_ms_valid = 1'b1;
    check_cycle();
    chk("max_block_mem", 128'(ms_allowin), 128'(1'b0));
    advance();
    cur = mk(LD_OP_LW, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0000_0055, 32'h604);
    check_cycle();
    chk("max_allow_alu", 128'(ms_allowin), 128'(1'b1));
    advance(); es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'hCAFE_0000;
    repeat (3) cyc();
    data_ok = 1'b0;
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd15, 32'h0000_4008, 32'h608);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'h0000_0077;
    check_cycle();
    chk("max_drained_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    advance(); data_ok = 1'b0;

    // Reset in WAIT with two orphans outstanding.
    for (int i = 0; i < 2; i++) begin
      cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd16, 32'h0000_5000, 32'h700 + 32'(4 * i));
      es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
      ms_flush = 1'b1; cyc(); ms_flush = 1'b0;
    end
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd17, 32'h0000_5004, 32'h708);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("midrst_allowin", 128'(ms_allowin), 128'(1'b1));
    chk("midrst_wsv", 128'(ms_to_ws_valid), 128'(1'b0));
    chk("midrst_dsv", 128'(ds_valid), 128'(1'b0));
    chk("midrst_blk", 128'(ds_block), 128'(1'b0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur = mk(LD_OP_LW, 1'b1, 1'b1, 1'b1, 5'd18, 32'h0000_6000, 32'h800);
    es_to_ms_valid = 1'b1; cyc(); es_to_ms_valid = 1'b0;
    data_ok = 1'b1; rdata = 32'h3333_4444;
    check_cycle();
    chk("postrst_wsv", 128'(ms_to_ws_valid), 128'(1'b1));
    chk("postrst_res", 128'(ms_to_ws_bus[63:32]), 128'(32'h3333_4444));
    advance(); data_ok = 1'b0;

    // Randomized traffic: first half slow responses/heavy flushing, then busier.
    for (int n = 0; n < 2000; n++) begin
      es_to_ms_valid = 1'($urandom_range(0, 1));
      cur = rand_instr();
      ws_allowin = ($urandom_range(0, 3) != 0);
      ms_flush = ($urandom_range(0, (n < 1000) ? 5 : 12) == 0);
      data_ok = (resp_q.size() > 0) && ($urandom_range(0, (n < 1000) ? 6 : 2) == 0);
      rdata = data_ok ? resp_q[0] : $urandom;
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
